// File: rtl/fifo_rd_arbiter_if.sv
// Stream and fifo B-side bundle for fifo_rd_arbiter.
// master = arbiter side, slave = fifo/sink side.
interface fifo_rd_arbiter_if #(
  parameter int DW = 36
);
  logic [7:0]    fifo_empty_i;
  logic [2:0]    fifo_sel_o;
  logic          fifo_re_o;
  logic [DW-1:0] fifo_dat_i;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [DW-1:0] out_dat_o;
  logic          out_hdr_o;
  logic          out_last_o;
  logic [2:0]    out_port_o;

  modport master (
    input  fifo_empty_i,
    input  fifo_dat_i,
    input  out_ready_i,
    output fifo_sel_o,
    output fifo_re_o,
    output out_valid_o,
    output out_dat_o,
    output out_hdr_o,
    output out_last_o,
    output out_port_o
  );

  modport slave (
    output fifo_empty_i,
    output fifo_dat_i,
    output out_ready_i,
    input  fifo_sel_o,
    input  fifo_re_o,
    input  out_valid_o,
    input  out_dat_o,
    input  out_hdr_o,
    input  out_last_o,
    input  out_port_o
  );
endinterface

// File: rtl/fifo_rd_arbiter.sv
// Drains the 8-port fifo B side one transaction at a time into a skid-buffered stream.
// FIFO_RD_FIXED_PRIO_EN: fixed lowest-port-first grant instead of round-robin.
module fifo_rd_arbiter #(
  parameter logic [7:0] PORT_MASK = 8'hFF,
  parameter int         DW        = 36
) (
  input  logic               clk,
  input  logic               rst,
  fifo_rd_arbiter_if.master  bus,
  output logic               busy_o
);

  typedef enum logic [1:0] {
    IDLE,
    POP_HDR,
    DEC_HDR,
    POP_DAT
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [2:0]    sel;
  logic [2:0]    sel_nxt;
  logic [2:0]    beat;
  logic [2:0]    beat_nxt;

  logic          inflight;
  logic          inf_hdr;
  logic          inf_last;
  logic          cap_last;

  logic [DW-1:0] sk_dat  [2];
  logic [1:0]    sk_hdr;
  logic [1:0]    sk_last;
  logic [2:0]    sk_port [2];
  logic          wp;
  logic          rp;
  logic [1:0]    cnt;

  logic          deq;
  logic          room;
  logic          pop;
  logic [7:0]    rel;
  logic [7:0]    elig;
  logic          grant;
  logic [2:0]    gnt_port;
  logic [2:0]    base;
  logic [2:0]    idx;

`ifdef FIFO_RD_FIXED_PRIO_EN
  assign base = 3'd0;
`else
  logic [2:0] rr_ptr;

  // advance the round-robin pointer past the port just released
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= 3'd0;
    end else if ((state == DEC_HDR && !bus.fifo_dat_i[DW-1]) ||
                 (state == POP_DAT && pop && beat == 3'd0)) begin
      rr_ptr <= sel + 3'd1;
    end
  end

  assign base = rr_ptr;
`endif

  assign deq  = bus.out_valid_o & bus.out_ready_i;
  // words held or in flight, minus the one leaving, must leave a free slot
  assign room = ({1'b0, cnt} + {2'b0, inflight})
                <= (3'd1 + {2'b0, deq});
  assign pop  = (state == POP_HDR || state == POP_DAT) &&
                !bus.fifo_empty_i[sel] && room;

  assign bus.fifo_re_o  = pop;
  assign bus.fifo_sel_o = sel;
  assign busy_o         = (state != IDLE);

  // eligible ports; a port whose final word is still in flight is skipped
  always_comb begin
    rel = 8'd0;
    if (inflight) rel[sel] = 1'b1;
    elig = ~bus.fifo_empty_i & PORT_MASK & ~rel;
  end

  // first eligible port searching upward from base, wrapping mod 8
  always_comb begin
    grant    = 1'b0;
    gnt_port = base;
    idx      = base;
    for (int i = 0; i < 8; i++) begin
      idx = base + 3'(i);
      if (!grant && elig[idx]) begin
        grant    = 1'b1;
        gnt_port = idx;
      end
    end
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sel   <= 3'd0;
      beat  <= 3'd0;
    end else begin
      state <= state_nxt;
      sel   <= sel_nxt;
      beat  <= beat_nxt;
    end
  end

  // next state: grant, header pop, header decode, data pops
  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    beat_nxt  = beat;
    unique case (state)
      IDLE: begin
        if (grant) begin
          sel_nxt   = gnt_port;
          state_nxt = POP_HDR;
        end
      end
      POP_HDR: begin
        if (pop) state_nxt = DEC_HDR;
      end
      DEC_HDR: begin
        if (bus.fifo_dat_i[DW-1]) begin
          beat_nxt  = bus.fifo_dat_i[DW-2 -: 3];
          state_nxt = POP_DAT;
        end else begin
          state_nxt = IDLE;
        end
      end
      POP_DAT: begin
        if (pop) begin
          if (beat == 3'd0) state_nxt = IDLE;
          else              beat_nxt  = beat - 3'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // tags of the word whose RAM read is in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight <= 1'b0;
      inf_hdr  <= 1'b0;
      inf_last <= 1'b0;
    end else begin
      inflight <= pop;
      if (pop) begin
        inf_hdr  <= (state == POP_HDR);
        inf_last <= (state == POP_DAT) && (beat == 3'd0);
      end
    end
  end

  // a read header is its own last word
  assign cap_last = inf_hdr ? ~bus.fifo_dat_i[DW-1] : inf_last;

  // two-entry skid buffer: capture in flight word, release on handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        sk_dat[i]  <= '0;
        sk_port[i] <= 3'd0;
      end
      sk_hdr  <= 2'b0;
      sk_last <= 2'b0;
      wp      <= 1'b0;
      rp      <= 1'b0;
      cnt     <= 2'd0;
    end else begin
      if (inflight) begin
        sk_dat[wp]  <= bus.fifo_dat_i;
        sk_hdr[wp]  <= inf_hdr;
        sk_last[wp] <= cap_last;
        sk_port[wp] <= sel;
        wp          <= ~wp;
      end
      if (deq) rp <= ~rp;
      cnt <= cnt + {1'b0, inflight} - {1'b0, deq};
    end
  end

  assign bus.out_valid_o = (cnt != 2'd0);
  assign bus.out_dat_o   = sk_dat[rp];
  assign bus.out_hdr_o   = sk_hdr[rp];
  assign bus.out_last_o  = sk_last[rp];
  assign bus.out_port_o  = sk_port[rp];

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Scoreboard bench for fifo_rd_arbiter: fifo model, expected-word queue, monitor.
// Honours FIFO_RD_FIXED_PRIO_EN for the grant-order vector.
module tb_fifo_rd_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_rd_arbiter_if #(.DW(36)) bus ();
  fifo_rd_arbiter_if #(.DW(36)) mbus ();
  logic busy;
  logic mbusy;

  fifo_rd_arbiter #(.PORT_MASK(8'hFF), .DW(36)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus.master),
    .busy_o (busy)
  );

  fifo_rd_arbiter #(.PORT_MASK(8'hFE), .DW(36)) dut_m (
    .clk    (clk),
    .rst    (rst),
    .bus    (mbus.master),
    .busy_o (mbusy)
  );

  logic [35:0] fq [8][$];
  logic [40:0] exp_q [$];
  int          poplog [$];
  int          cyc = 0;
  int          npop = 0;
  int          nacc = 0;
  int          max_out = 0;
  logic        uflow = 1'b0;
  logic        m_seen = 1'b0;
  int          rmode = 1;
  int          checks = 0;
  int          passes = 0;
  logic        held = 1'b0;
  logic [41:0] held_val = '0;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
  endtask

  // fifo B side: 1-cycle read latency, empty flags follow queue depth
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      npop <= 0;
      nacc <= 0;
    end else begin
      if (bus.fifo_re_o) begin
        npop <= npop + 1;
        poplog.push_back(cyc);
        if (fq[bus.fifo_sel_o].size() == 0) uflow <= 1'b1;
        else bus.fifo_dat_i <= fq[bus.fifo_sel_o].pop_front();
      end
      if (bus.out_valid_o && bus.out_ready_i) nacc <= nacc + 1;
    end
    for (int p = 0; p < 8; p++)
      bus.fifo_empty_i[p] <= (fq[p].size() == 0);
  end

  // downstream ready pattern: 0 hold, 1 always, 2 toggle
  always @(posedge clk) begin
    #1;
    case (rmode)
      0:       bus.out_ready_i = 1'b0;
      2:       bus.out_ready_i = ~bus.out_ready_i;
      default: bus.out_ready_i = 1'b1;
    endcase
  end

  initial begin
    mbus.fifo_empty_i = 8'hFE;
    mbus.fifo_dat_i   = '0;
    mbus.out_ready_i  = 1'b1;
  end

  // monitor: compare accepted words, check hold stability and occupancy
  always @(negedge clk) begin
    if (!rst) begin
      if (mbus.fifo_re_o || mbus.out_valid_o || mbusy) m_seen = 1'b1;
      if (npop - nacc > max_out) max_out = npop - nacc;
      if (held)
        chk("stable", {bus.out_valid_o, bus.out_dat_o, bus.out_hdr_o,
                       bus.out_last_o, bus.out_port_o}, held_val);
      held = 1'b0;
      if (bus.out_valid_o) begin
        if (bus.out_ready_i) begin
          if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL extra_word got=%0h", bus.out_dat_o);
          end else begin
            chk("word", {bus.out_dat_o, bus.out_hdr_o, bus.out_last_o,
                         bus.out_port_o}, exp_q.pop_front());
          end
        end else begin
          held     = 1'b1;
          held_val = {1'b1, bus.out_dat_o, bus.out_hdr_o,
                      bus.out_last_o, bus.out_port_o};
        end
      end
    end else begin
      held = 1'b0;
    end
  end

  task automatic put(input int p, input logic [35:0] w);
    fq[p].push_back(w);
  endtask

  task automatic expect_w(input logic [35:0] w, input logic h,
                          input logic l, input int p);
    exp_q.push_back({w, h, l, 3'(p)});
  endtask

  task automatic wait_done(input string nm);
    int  n;
    logic pend;
    n = 0;
    pend = 1'b1;
    while (pend && n < 400) begin
      @(posedge clk);
      #1;
      n++;
      pend = (exp_q.size() != 0) || busy || bus.out_valid_o;
    end
    if (pend) begin
      checks++;
      $display("FAIL %s timeout pending=%0d", nm, exp_q.size());
    end
  endtask

  logic [35:0] h;
  logic [35:0] w;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", bus.out_valid_o, 0);
    chk("rst_re", bus.fifo_re_o, 0);
    chk("rst_sel", bus.fifo_sel_o, 0);
    chk("rst_busy", busy, 0);
    chk("rst_dat", {bus.out_dat_o, bus.out_hdr_o, bus.out_last_o,
                    bus.out_port_o}, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // single read header on port 2
    poplog.delete();
    h = 36'h0_8000_0100;
    put(2, h);
    expect_w(h, 1, 1, 2);
    wait_done("read");
    chk("read_pops", poplog.size(), 1);

    // write burst bl=3 on port 0
    poplog.delete();
    h = {1'b1, 3'd3, 32'h40};
    put(0, h);
    expect_w(h, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      w = {4'hF, 32'hA0 + 32'(i)};
      put(0, w);
      expect_w(w, 0, i == 3, 0);
    end
    wait_done("burst");
    chk("burst_pops", poplog.size(), 5);
    if (poplog.size() == 5)
      chk("burst_span", poplog[4] - poplog[0], 5);

    // move round-robin pointer to 6 via a read on port 5
    h = {1'b0, 3'd0, 32'h500};
    put(5, h);
    expect_w(h, 1, 1, 5);
    wait_done("rr_setup");

    // ports 1, 5, 7 all pending at once
    put(1, {1'b0, 3'd0, 32'h1001});
    put(5, {1'b0, 3'd0, 32'h5005});
    put(7, {1'b0, 3'd0, 32'h7007});
`ifdef FIFO_RD_FIXED_PRIO_EN
    expect_w({1'b0, 3'd0, 32'h1001}, 1, 1, 1);
    expect_w({1'b0, 3'd0, 32'h5005}, 1, 1, 5);
    expect_w({1'b0, 3'd0, 32'h7007}, 1, 1, 7);
`else
    expect_w({1'b0, 3'd0, 32'h7007}, 1, 1, 7);
    expect_w({1'b0, 3'd0, 32'h1001}, 1, 1, 1);
    expect_w({1'b0, 3'd0, 32'h5005}, 1, 1, 5);
`endif
    wait_done("rr_order");

    // bl=7 burst on port 4 under toggling backpressure
    rmode = 2;
    h = {1'b1, 3'd7, 32'h400};
    put(4, h);
    expect_w(h, 1, 0, 4);
    for (int i = 0; i < 8; i++) begin
      w = {4'h3, 32'hB00 + 32'(i)};
      put(4, w);
      expect_w(w, 0, i == 7, 4);
    end
    wait_done("backpressure");
    rmode = 1;

    // starved burst: second data word arrives after 20 empty cycles
    h = {1'b1, 3'd1, 32'h600};
    put(6, h);
    expect_w(h, 1, 0, 6);
    put(6, {4'h1, 32'hC0});
    expect_w({4'h1, 32'hC0}, 0, 0, 6);
    expect_w({4'h2, 32'hC1}, 0, 1, 6);
    repeat (20) @(posedge clk);
    #1;
    chk("starve_busy", busy, 1);
    chk("starve_left", exp_q.size(), 1);
    put(6, {4'h2, 32'hC1});
    wait_done("starve");

    // reset in the middle of a stalled burst
    rmode = 0;
    put(3, {1'b1, 3'd7, 32'h300});
    put(3, {4'hF, 32'hD0});
    put(3, {4'hF, 32'hD1});
    repeat (12) @(posedge clk);
    #1;
    chk("pre_rst_busy", busy, 1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", bus.out_valid_o, 0);
    chk("mid_rst_re", bus.fifo_re_o, 0);
    chk("mid_rst_sel", bus.fifo_sel_o, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_out", {bus.out_dat_o, bus.out_hdr_o, bus.out_last_o,
                        bus.out_port_o}, 0);
    exp_q.delete();
    fq[3].delete();
    rmode = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    h = {1'b0, 3'd0, 32'h4444};
    put(4, h);
    expect_w(h, 1, 1, 4);
    wait_done("post_rst");

    chk("max_outstanding_le2", max_out <= 2, 1);
    chk("no_underflow", uflow, 0);
    chk("masked_port_idle", m_seen, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/fifo_rd_arbiter.md
Name: fifo_rd_arbiter

Overview:
- Sits on the B (read) side of the 8-port shared-RAM fifo and drains it towards the SDRAM command/data FSM.
- Selects a non-empty port and pops one complete transaction from it: a header word, plus burst data words for writes.
- Drives fifo_sel/re with correct 1-cycle RAM read latency.
- Presents the words on a valid/ready stream through a 2-entry skid buffer.

Parameters:
- PORT_MASK, 8'hFF: bit n=1 means port n is eligible; masked ports are never granted.
- DW, 36: fifo word width; the header and data field layout below is fixed for 36.

Ports:
- clk  in  1  single clock; the same clock as the fifo b_clk.
- rst  in  1  asynchronous, active-high reset.
- fifo_empty_i  in  8  per-port empty flags from the fifo B side.
- fifo_sel_o  out  3  port select to the fifo B side.
- fifo_re_o  out  1  pop strobe to the fifo B side.
- fifo_dat_i  in  36  fifo read data; valid in the cycle after fifo_re_o=1, with fifo_sel_o held.
- out_valid_o  out  1  stream word valid.
- out_ready_i  in  1  downstream accepts the word.
- out_dat_o  out  36  stream word.
- out_hdr_o  out  1  word is a header.
- out_last_o  out  1  last word of the transaction.
- out_port_o  out  3  source port of the word.
- busy_o  out  1  a transaction is in progress.

Behaviour:
- Word format:
  - Header: [35]=we, [34:32]=bl (beats-1, 0..7), [31:0]=address.
  - Data word: [35:32]=byte select, [31:0]=data.
  - A read transaction is the header only. A write transaction is the header followed by bl+1 data words from the same port.
- Reset (asynchronous): state=IDLE; rr_ptr=0; skid buffer empty; in-flight flag=0. Outputs out_valid_o=0, fifo_re_o=0, fifo_sel_o=0, busy_o=0, out_*=0. A transaction in progress is abandoned.
- Pop rule: fifo_re_o=1 only when all of the following hold:
  - state is POP_HDR or POP_DAT;
  - fifo_empty_i[sel]=0 in that cycle;
  - (skid_count + inflight - (out_valid_o & out_ready_i)) <= 1.
  - At most one pop per cycle. The skid buffer therefore never overflows, and sustained throughput is 1 word/clk when out_ready_i=1.
- Capture: one cycle after a pop, fifo_dat_i is written into the skid buffer with its tags (hdr, last, port). A word enters the skid buffer no earlier than 1 cycle after its pop and leaves on out_valid_o & out_ready_i.
- fifo_sel_o is held constant from grant until the final pop's data is captured.
- FSM:
  - IDLE: if any (~fifo_empty_i & PORT_MASK), grant the first eligible port searching from rr_ptr upward (mod 8). Latch sel, busy_o=1, go to POP_HDR. Otherwise stay; busy_o=0.
  - POP_HDR: on pop, go to DEC_HDR.
  - DEC_HDR: header captured this cycle.
    - we=0: the header is tagged last; rr_ptr=sel+1; go to IDLE.
    - we=1: beat_cnt=bl; go to POP_DAT.
  - POP_DAT: each pop decrements beat_cnt. The pop with beat_cnt=0 is tagged last; then rr_ptr=sel+1 and go to IDLE.
  - While empty mid-burst, stay in POP_DAT indefinitely; there is no timeout.
- IDLE→grant has a 1-cycle minimum, so back-to-back transactions have a one-cycle gap on the fifo side.
- out_hdr_o/out_last_o/out_port_o are stable while out_valid_o=1 and out_ready_i=0. out_valid_o never drops without a handshake.
- Simultaneous events:
  - A capture and a dequeue in the same cycle keep the count unchanged.
  - A grant ignores flags of the port being released in the same cycle.
- rr_ptr wrap: 7+1 → 0.

Optional Feature:
- Macro: FIFO_RD_FIXED_PRIO_EN.
- Defined: the IDLE grant is fixed priority, lowest-numbered eligible non-empty port first; rr_ptr is not implemented.
- Undefined: round-robin as above.

Test Plan:
- Read transaction: port 2 holds header 36'h0_8000_0100 (we=0, bl=0) → one pop with fifo_sel_o=2; one output word, hdr=1, last=1, port=2; rr_ptr=3.
- Write burst: port 0 holds header we=1, bl=3, adr=0x40, then 4 data words 0xA0..0xA3, sel=F, out_ready_i=1 → 5 output words in order, last only on 0xA3; 5 pops in 6 cycles after grant.
- Round-robin: ports 1, 5 and 7 each hold one read header, rr_ptr=6 → grant order 7, 1, 5. With FIFO_RD_FIXED_PRIO_EN the order is 1, 5, 7.
- Backpressure: write burst bl=7 with out_ready_i toggled 1010… → no word lost or duplicated; skid count never exceeds 2; fifo_re_o is 0 whenever the pop rule is false.
- Starved burst: header bl=1 then only 1 data word, fifo empty for 20 cycles, then the 2nd word is written → FSM waits in POP_DAT with busy_o=1; last is tagged on the 2nd word.
- Mask and reset: PORT_MASK=8'hFE with port 0 non-empty → never granted. Asserting rst during POP_DAT → all outputs 0 immediately; after release, state=IDLE.
